pong_game_control: RTL and testbench
====================================

Name: pong_game_control

Overview:
- Game-state controller downstream of the ball control stage.
- Consumes ball position and both paddle positions, detects misses at the left and right edge columns, and keeps the two scores.
- Drives the `running` level that gates (and, when low, recentres) the ball control stage; sequences serve pauses and game over.
- Sits between the ball/paddle stages and the score display/renderer.

Parameters:
- GAME_WIDTH, 40, board width in game units; the right edge column is GAME_WIDTH-1.
- GAME_HEIGHT, 30, board height in game units; used only for input range checks.
- PADDLE_HEIGHT, 6, paddle length in game units; the paddle occupies rows paddle_y .. paddle_y+PADDLE_HEIGHT-1.
- SCORE_LIMIT, 9, score that ends the game; legal range 1..15.
- PAUSE_CYCLES, 25000000, length of the post-point pause in clock cycles (1 s at 25 MHz); must be >= 2.

Ports:
- clock, input, 1, system clock (25 MHz).
- reset_n, input, 1, asynchronous active-low reset.
- start, input, 1, start button level; its rising edge is the event.
- ball_x, input, 6, ball column from the ball control stage.
- ball_y, input, 6, ball row from the ball control stage.
- paddle1_y, input, 6, top row of the left paddle (column 0).
- paddle2_y, input, 6, top row of the right paddle (column GAME_WIDTH-1).
- running, output, 1, high only in PLAY; gates the ball stage.
- score1, output, 4, left player score.
- score2, output, 4, right player score.
- winner, output, 2, 0 = none, 1 = left player, 2 = right player.
- point_pulse, output, 1, one-cycle strobe on every score increment.

Behaviour:
- Reset (asynchronous, reset_n low): state = IDLE, running = 0, score1 = score2 = 0, winner = 0, point_pulse = 0, pause counter = 0, start_d = 1.
  - Resetting start_d to 1 means a start held through reset release is not an edge.
- Reset mid-game aborts immediately to IDLE; no score is retained.
- Start edge: start_rise = start & ~start_d, where start_d is a registered copy of start, updated every cycle.
- hit1 = (ball_y >= paddle1_y) && (ball_y <= paddle1_y + PADDLE_HEIGHT - 1).
  - Compute in 7 bits so paddle1_y + PADDLE_HEIGHT cannot wrap.
  - hit2 is the same expression using paddle2_y.
- miss1 = (ball_x == 0) && !hit1, which scores for the right player.
- miss2 = (ball_x == GAME_WIDTH-1) && !hit2, which scores for the left player.
- miss1 and miss2 are mutually exclusive by construction.
- All outputs are registered; every decision is visible one clock after the inputs that cause it.
- IDLE (running = 0):
  - start_rise -> PLAY, with score1, score2 and winner cleared to 0 on the same edge.
- PLAY (running = 1):
  - miss2 -> score1 += 1 and point_pulse = 1 for one cycle.
  - miss1 -> score2 += 1 and point_pulse = 1 for one cycle.
  - If the incremented score equals SCORE_LIMIT: next state OVER and winner set (1 or 2) on the same edge.
  - Otherwise: next state POINT and pause counter loaded with 0.
  - No miss: stay in PLAY. start_rise is ignored.
- POINT (running = 0):
  - The counter increments each cycle; at PAUSE_CYCLES-1 -> PLAY.
  - running is therefore low for exactly PAUSE_CYCLES cycles, which guarantees the ball stage recentres.
  - Misses are not evaluated while in POINT. start_rise is ignored.
- OVER (running = 0):
  - Scores and winner are held.
  - start_rise -> PLAY with scores and winner cleared (immediate rematch).
- Only one score increment per point: the state leaves PLAY on the scoring edge, so a ball that stays on the edge column cannot re-score.
- Scores saturate at SCORE_LIMIT. An increment beyond the limit is unreachable and must not wrap.
- Input ranges are not checked: a ball_x outside 0..GAME_WIDTH-1 never matches an edge column and produces no miss.
- point_pulse is high only in the cycle after the scoring edge; it is 0 in every other cycle and state.

Test Plan:
- Reset release with start held high, then no start toggle -> stays IDLE, running = 0, scores 0/0, winner 0.
- Start rising edge; drive ball_x = 0, ball_y = 20, paddle1_y = 5 -> next cycle score2 = 1, point_pulse = 1 for exactly one cycle, running = 0 for exactly PAUSE_CYCLES (use PAUSE_CYCLES = 4), then running = 1.
- Paddle-edge hits: ball_x = 0, paddle1_y = 10, ball_y = 10, then ball_y = 15 -> no score either time. ball_y = 16 -> score2 increments. Repeat on the right edge column 39 with paddle2_y.
- Hold ball_x = 39 with a miss for 100 cycles -> score1 increments exactly once.
- SCORE_LIMIT = 3, left player scores 3 times -> third point gives state OVER, winner = 1, score1 = 3, running stays 0. Next start edge -> scores 0/0, winner = 0, running = 1.
- Assert reset_n low mid-POINT with score1 = 2 -> all outputs return to reset values asynchronously, without waiting for a clock edge.

Source files
------------

// File: rtl/pong_game_control_if.sv
// Signal bundle between the ball/paddle stages, the pong game controller and the
// score display. The slave side is the controller.
interface pong_game_control_if;
  logic       start;
  logic [5:0] ball_x;
  logic [5:0] ball_y;
  logic [5:0] paddle1_y;
  logic [5:0] paddle2_y;
  logic       running;
  logic [3:0] score1;
  logic [3:0] score2;
  logic [1:0] winner;
  logic       point_pulse;

  modport master (
    output start, ball_x, ball_y, paddle1_y, paddle2_y,
    input  running, score1, score2, winner, point_pulse
  );

  modport slave (
    input  start, ball_x, ball_y, paddle1_y, paddle2_y,
    output running, score1, score2, winner, point_pulse
  );
endinterface

// File: rtl/pong_game_control.sv
// Pong game-state controller: detects edge-column misses, keeps both scores,
// sequences serve pauses and game over, and gates the ball stage via running.
module pong_game_control #(
  parameter int GAME_WIDTH    = 40,
  parameter int GAME_HEIGHT   = 30,
  parameter int PADDLE_HEIGHT = 6,
  parameter int SCORE_LIMIT   = 9,
  parameter int PAUSE_CYCLES  = 25000000
) (
  input  logic                clock,
  input  logic                reset_n,
  pong_game_control_if.slave  pu
);

  localparam int         CNT_W     = $clog2(PAUSE_CYCLES);
  localparam logic [5:0] RIGHT_COL = 6'(GAME_WIDTH - 1);
  localparam logic [3:0] LIMIT     = 4'(SCORE_LIMIT);

  if (SCORE_LIMIT < 1 || SCORE_LIMIT > 15) begin : g_bad_limit
    $error("SCORE_LIMIT must be in 1..15");
  end
  if (PAUSE_CYCLES < 2) begin : g_bad_pause
    $error("PAUSE_CYCLES must be at least 2");
  end
  if (PADDLE_HEIGHT > GAME_HEIGHT) begin : g_bad_paddle
    $error("PADDLE_HEIGHT exceeds GAME_HEIGHT");
  end

  typedef enum logic [1:0] {IDLE, PLAY, POINT, OVER} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         score1_q, score1_d;
  logic [3:0]         score2_q, score2_d;
  logic [1:0]         winner_q, winner_d;
  logic               running_q, running_d;
  logic               pulse_q, pulse_d;
  logic               start_q;

  logic start_rise, hit1, hit2, miss1, miss2;

  // 7-bit compare so paddle_y + PADDLE_HEIGHT - 1 cannot wrap past 63.
  assign hit1 = ({1'b0, pu.ball_y} >= {1'b0, pu.paddle1_y}) &&
                ({1'b0, pu.ball_y} <= {1'b0, pu.paddle1_y} + 7'(PADDLE_HEIGHT - 1));
  assign hit2 = ({1'b0, pu.ball_y} >= {1'b0, pu.paddle2_y}) &&
                ({1'b0, pu.ball_y} <= {1'b0, pu.paddle2_y} + 7'(PADDLE_HEIGHT - 1));
  assign miss1      = (pu.ball_x == 6'd0) && !hit1;
  assign miss2      = (pu.ball_x == RIGHT_COL) && !hit2;
  assign start_rise = pu.start & ~start_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    score1_d = score1_q;
    score2_d = score2_q;
    winner_d = winner_q;
    pulse_d  = 1'b0;
    case (state_q)
      IDLE, OVER: begin
        if (start_rise) begin
          state_d  = PLAY;
          score1_d = 4'd0;
          score2_d = 4'd0;
          winner_d = 2'd0;
        end
      end
      PLAY: begin
        if (miss2) begin
          pulse_d = 1'b1;
          if (score1_q < LIMIT) score1_d = score1_q + 4'd1;
          if (score1_d == LIMIT) begin
            state_d  = OVER;
            winner_d = 2'd1;
          end else begin
            state_d = POINT;
            cnt_d   = '0;
          end
        end else if (miss1) begin
          pulse_d = 1'b1;
          if (score2_q < LIMIT) score2_d = score2_q + 4'd1;
          if (score2_d == LIMIT) begin
            state_d  = OVER;
            winner_d = 2'd2;
          end else begin
            state_d = POINT;
            cnt_d   = '0;
          end
        end
      end
      POINT: begin
        // Holding running low this long lets the ball stage recentre.
        if (cnt_q == CNT_W'(PAUSE_CYCLES - 1)) state_d = PLAY;
        else                                   cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    running_d = (state_d == PLAY);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      score1_q  <= 4'd0;
      score2_q  <= 4'd0;
      winner_q  <= 2'd0;
      running_q <= 1'b0;
      pulse_q   <= 1'b0;
      start_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      score1_q  <= score1_d;
      score2_q  <= score2_d;
      winner_q  <= winner_d;
      running_q <= running_d;
      pulse_q   <= pulse_d;
      start_q   <= pu.start;
    end
  end

  assign pu.running     = running_q;
  assign pu.score1      = score1_q;
  assign pu.score2      = score2_q;
  assign pu.winner      = winner_q;
  assign pu.point_pulse = pulse_q;

endmodule

// File: tb/tb_pong_game_control.sv
// Directed bench for pong_game_control: stimulus queues the expected score state
// for every point; a monitor pops and compares on each point_pulse.
module tb_pong_game_control;
  localparam int LIMIT = 3;
  localparam int PAUSE = 4;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  pong_game_control_if pu ();

  pong_game_control #(
    .GAME_WIDTH(40), .GAME_HEIGHT(30), .PADDLE_HEIGHT(6),
    .SCORE_LIMIT(LIMIT), .PAUSE_CYCLES(PAUSE)
  ) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .pu     (pu)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0] s1;
    logic [3:0] s2;
    logic [1:0] w;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t mk(input int s1, input int s2, input int w);
    exp_t e;
    e.s1 = 4'(s1);
    e.s2 = 4'(s2);
    e.w  = 2'(w);
    return e;
  endfunction

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  // Counts negedges with running low; bounded so a stuck pause cannot hang.
  task automatic wait_play(output int n);
    n = 0;
    while (pu.running == 1'b0 && n < 20) begin
      n++;
      @(negedge clock);
    end
  endtask

  task automatic miss_and_pause(input logic [5:0] x, input logic [5:0] y,
                                input exp_t e, input string name);
    int n;
    exp_q.push_back(e);
    pu.ball_x = x;
    pu.ball_y = y;
    tick();
    pu.ball_x = 6'd20;
    pu.ball_y = 6'd15;
    wait_play(n);
    check({name, "_pause_len"}, n, PAUSE);
  endtask

  // Scoreboard monitor: each point_pulse consumes one expected entry.
  always @(negedge clock) begin
    exp_t e;
    if (reset_n && pu.point_pulse) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 1, 0);
      end else begin
        e = exp_q.pop_front();
        $display("point: score1=%0d score2=%0d winner=%0d running=%0d",
                 pu.score1, pu.score2, pu.winner, pu.running);
        check("pt_score1",  int'(pu.score1),  int'(e.s1));
        check("pt_score2",  int'(pu.score2),  int'(e.s2));
        check("pt_winner",  int'(pu.winner),  int'(e.w));
        check("pt_running", int'(pu.running), 0);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int hi;
    pu.start     = 1'b1;
    pu.ball_x    = 6'd20;
    pu.ball_y    = 6'd15;
    pu.paddle1_y = 6'd10;
    pu.paddle2_y = 6'd10;
    reset_n      = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (3) tick();
    check("rst_running", int'(pu.running), 0);
    check("rst_score1",  int'(pu.score1), 0);
    check("rst_score2",  int'(pu.score2), 0);
    check("rst_winner",  int'(pu.winner), 0);
    check("rst_pulse",   int'(pu.point_pulse), 0);

    pu.start = 1'b0; tick();
    pu.start = 1'b1; tick();
    check("start_running", int'(pu.running), 1);

    pu.paddle1_y = 6'd5;
    miss_and_pause(6'd0, 6'd20, mk(0, 1, 0), "left_miss");
    pu.paddle1_y = 6'd10;

    pu.ball_x = 6'd0; pu.ball_y = 6'd10; tick();
    check("hit1_top_score2", int'(pu.score2), 1);
    check("hit1_top_running", int'(pu.running), 1);
    pu.ball_y = 6'd15; tick();
    check("hit1_bot_score2", int'(pu.score2), 1);
    check("hit1_bot_running", int'(pu.running), 1);
    miss_and_pause(6'd0, 6'd16, mk(0, 2, 0), "left_below");

    pu.ball_x = 6'd39; pu.ball_y = 6'd10; tick();
    check("hit2_top_score1", int'(pu.score1), 0);
    pu.ball_y = 6'd15; tick();
    check("hit2_bot_score1", int'(pu.score1), 0);
    check("hit2_bot_running", int'(pu.running), 1);
    miss_and_pause(6'd39, 6'd16, mk(1, 2, 0), "right_below");

    pu.ball_x = 6'd63; pu.ball_y = 6'd0; tick();
    check("oor_score1", int'(pu.score1), 1);
    check("oor_score2", int'(pu.score2), 2);
    check("oor_running", int'(pu.running), 1);

    // Ball left sitting on the right column through the whole pause.
    exp_q.push_back(mk(2, 2, 0));
    pu.ball_x = 6'd39; pu.ball_y = 6'd0; tick();
    wait_play(n);
    pu.ball_x = 6'd20;
    check("hold_pause_len", n, PAUSE);
    check("hold_score1", int'(pu.score1), 2);

    exp_q.push_back(mk(3, 2, 1));
    pu.ball_x = 6'd39; tick();
    hi = 0;
    repeat (100) begin
      tick();
      if (pu.running) hi++;
    end
    check("over_running_cycles", hi, 0);
    check("over_score1", int'(pu.score1), 3);
    check("over_score2", int'(pu.score2), 2);
    check("over_winner", int'(pu.winner), 1);

    pu.ball_x = 6'd20;
    pu.start = 1'b0; tick();
    pu.start = 1'b1; tick();
    check("rematch_score1", int'(pu.score1), 0);
    check("rematch_score2", int'(pu.score2), 0);
    check("rematch_winner", int'(pu.winner), 0);
    check("rematch_running", int'(pu.running), 1);

    miss_and_pause(6'd39, 6'd0, mk(1, 0, 0), "left_again");
    exp_q.push_back(mk(2, 0, 0));
    pu.ball_x = 6'd39; pu.ball_y = 6'd0; tick();
    pu.ball_x = 6'd20;
    #1;
    check("pre_rst_score1", int'(pu.score1), 2);
    reset_n = 1'b0;
    #1;
    check("async_rst_running", int'(pu.running), 0);
    check("async_rst_score1",  int'(pu.score1), 0);
    check("async_rst_score2",  int'(pu.score2), 0);
    check("async_rst_winner",  int'(pu.winner), 0);
    check("async_rst_pulse",   int'(pu.point_pulse), 0);
    tick();
    reset_n = 1'b1;
    repeat (3) tick();
    check("post_rst_running", int'(pu.running), 0);
    check("post_rst_score1", int'(pu.score1), 0);
    check("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
